// File: rtl/emmk_xbus_pkg.sv
// rtl/emmk_xbus_pkg.sv - command fields, sizes, status codes and states for the xbus responder
package emmk_xbus_pkg;

  localparam int WR_BIT   = 7;
  localparam int SIZE_LSB = 0;

  // Encoding 2'd3 is the illegal size and is reported as an alignment error.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_ALIGN = 8'h01;
  localparam logic [7:0] ST_RANGE = 8'h02;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_EXEC  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << lo;
      SZ_H:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/emmk_xbus_mem.sv
// rtl/emmk_xbus_mem.sv - DEPTH x 32 register RAM with byte enables and async clear
module emmk_xbus_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Callers only read addresses already checked against DEPTH.
  assign rdata = mem[addr];

endmodule

// File: rtl/emmk_xbus_responder.sv
// rtl/emmk_xbus_responder.sv - byte-serial bus target: frame decode, RAM access, status/data response
module emmk_xbus_responder
  import emmk_xbus_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [1:0]  cmd_size_q, cmd_size_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  rem_q, rem_d;
  logic        busy_q, busy_d;

  logic        in_fire, out_fire;
  logic        bad_align, bad_range, mem_we;
  logic [7:0]  status;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  assign in_ready  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign out_valid = (state_q == S_RESP);
  assign out_data  = resp_q[7:0];
  assign busy      = busy_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Alignment (including the illegal size) outranks the range check.
  assign bad_align = (cmd_size_q == 2'd3)
                  || ((cmd_size_q == SZ_H) && addr_q[0])
                  || ((cmd_size_q == SZ_W) && (addr_q[1:0] != 2'b00));
  assign bad_range = ({18'd0, addr_q[15:2]} >= 32'(DEPTH));
  assign status    = bad_align ? ST_ALIGN : (bad_range ? ST_RANGE : ST_OK);
  assign mem_be    = lane_mask(cmd_size_q, addr_q[1:0]);

  emmk_xbus_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_size_d = cmd_size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;

    case (state_q)
      S_CMD: begin
        if (in_fire) begin
          cmd_wr_d   = in_data[WR_BIT];
          cmd_size_d = in_data[SIZE_LSB +: 2];
          cnt_d      = 3'd0;
          busy_d     = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (in_fire) begin
          if (cnt_q == 3'd0) begin
            addr_d[7:0] = in_data;
            cnt_d       = 3'd1;
          end else begin
            addr_d[15:8] = in_data;
            cnt_d        = 3'd0;
            state_d      = cmd_wr_q ? S_WDATA : S_EXEC;
          end
        end
      end
      S_WDATA: begin
        if (in_fire) begin
          wdata_d[8*cnt_q[1:0] +: 8] = in_data;
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_EXEC: begin
        mem_we  = cmd_wr_q && (status == ST_OK);
        // Status goes out first; the raw word follows only for a good read.
        resp_d  = {mem_rdata, status};
        rem_d   = (!cmd_wr_q && (status == ST_OK)) ? 3'd5 : 3'd1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_fire) begin
          resp_d = {8'h00, resp_q[39:8]};
          rem_d  = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            busy_d  = 1'b0;
            state_d = S_CMD;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CMD;
      cnt_q      <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_size_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_size_q <= cmd_size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
    end
  end

endmodule
